// File: rtl/ddc_i2s_frame_buffer.sv
// ---------------------------------------------------------------------------
// ddc_i2s_frame_buffer
//
// Sits between the DDC decimator and the I2S slave transmitter. Incoming wide
// signed I/Q samples are rounded and saturated to 24 bits and queued in a
// small FIFO. Exactly one pair is released per I2S frame, on the synchronised
// rising edge of LRCLK (mid-frame). The 24-bit outputs therefore never change
// near the frame-end load point, so a downstream multi-bit synchroniser can
// sample them safely.
//
// Ports:
//   clock        DDC clock, all logic on the rising edge
//   reset        asynchronous, active-high reset
//   in_real      signed I sample from the DDC (IN_W bits)
//   in_imag      signed Q sample from the DDC (IN_W bits)
//   in_valid     in_real/in_imag valid this cycle, no backpressure
//   LRCLK        I2S word clock, asynchronous to clock
//   clear_flags  synchronous clear of the sticky flags
//   out_real     held 24-bit I sample toward the I2S transmitter
//   out_imag     held 24-bit Q sample toward the I2S transmitter
//   out_update   one-cycle pulse when out_real/out_imag change
//   fifo_level   current FIFO occupancy, 0..DEPTH
//   overflow     sticky: an input sample was dropped because the FIFO was full
//   underflow    sticky: a frame started with the FIFO empty
// ---------------------------------------------------------------------------
module ddc_i2s_frame_buffer #(
  parameter int IN_W        = 32,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [IN_W-1:0]     in_real,
  input  logic signed [IN_W-1:0]     in_imag,
  input  logic                       in_valid,
  input  logic                       LRCLK,
  input  logic                       clear_flags,
  output logic [23:0]                out_real,
  output logic [23:0]                out_imag,
  output logic                       out_update,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Half an output LSB, added before truncation to round to nearest.
  localparam logic [IN_W:0] ROUND_BIAS = (IN_W + 1)'(1) << (IN_W - 25);

  // Round to 24 bits. The extra top bit of the sum only disagrees with the
  // result's sign bit when a large positive value rounds past full scale;
  // adding a positive bias can never push a negative value out of range.
  function automatic logic [23:0] round_sat(input logic signed [IN_W-1:0] x);
    logic [IN_W:0] s;
    s = {x[IN_W-1], x} + ROUND_BIAS;
    if (s[IN_W] != s[IN_W-1]) begin
      return 24'h7FFFFF;
    end
    return s[IN_W-1:IN_W-24];
  endfunction

  logic [23:0]            rnd_real;
  logic [23:0]            rnd_imag;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   sync_out;
  logic                   sync_valid;
  logic                   lr_prev;
  logic                   frame_edge;

  logic [47:0]            mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign rnd_real = round_sat(in_real);
  assign rnd_imag = round_sat(in_imag);

  assign sync_out   = sync_reg[SYNC_STAGES-1];
  assign sync_valid = sync_fill[SYNC_STAGES-1];
  assign frame_edge = sync_valid & sync_out & ~lr_prev;

  // Full/empty come from the level counter so the pointers can simply wrap.
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(DEPTH));
  assign pop        = frame_edge & ~fifo_empty;
  assign push       = in_valid & (~fifo_full | pop);
  assign drop       = in_valid & fifo_full & ~pop;

  // LRCLK synchroniser and rising-edge detector. The chain resets to zero, so
  // sync_fill marks when the stages hold real LRCLK samples; until then the
  // previous-value register is held high. Otherwise an LRCLK that is already
  // high at reset release would look like a fresh rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      sync_fill <= '0;
      lr_prev   <= 1'b1;
    end else begin
      sync_reg[0]  <= LRCLK;
      sync_fill[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i]  <= sync_reg[i-1];
        sync_fill[i] <= sync_fill[i-1];
      end
      lr_prev <= sync_valid ? sync_out : 1'b1;
    end
  end

  // Sample storage. It is left unreset on purpose: reset zeroes the pointers
  // and level, which discards whatever the array still holds.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {rnd_real, rnd_imag};
    end
  end

  // Pointers, occupancy and the held output pair. On a full push+pop both
  // pointers address the same slot; the read sees the old head because the
  // write only lands at the end of the cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_real   <= '0;
      out_imag   <= '0;
      out_update <= 1'b0;
    end else begin
      out_update <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_real <= mem[rd_ptr][47:24];
        out_imag <= mem[rd_ptr][23:0];
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

  // Sticky status flags. A new event in the same cycle as clear_flags wins,
  // so a clear can never hide an event it raced with.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (frame_edge && fifo_empty) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddc_i2s_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_ddc_i2s_frame_buffer
//
// Self-checking bench for ddc_i2s_frame_buffer. A queue-based reference model
// holds the rounded sample pairs that should be waiting in the FIFO. It also
// tracks the last released pair and the sticky flags. Rounding in the model is
// plain integer arithmetic: floor((x + half LSB) / LSB), clipped at +full
// scale. Inputs are driven on the falling edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_ddc_i2s_frame_buffer;

  localparam int IN_W        = 32;
  localparam int DEPTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LVL_W       = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [IN_W-1:0]   in_real;
  logic [IN_W-1:0]   in_imag;
  logic              in_valid;
  logic              LRCLK;
  logic              clear_flags;
  logic [23:0]       out_real;
  logic [23:0]       out_imag;
  logic              out_update;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              underflow;

  // Reference model state
  logic [47:0]       model_q[$];
  logic [47:0]       exp_out;
  logic              exp_ovf;
  logic              exp_unf;

  int                checks = 0;
  int                errors = 0;

  ddc_i2s_frame_buffer #(
    .IN_W(IN_W),
    .DEPTH(DEPTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_real(in_real),
    .in_imag(in_imag),
    .in_valid(in_valid),
    .LRCLK(LRCLK),
    .clear_flags(clear_flags),
    .out_real(out_real),
    .out_imag(out_imag),
    .out_update(out_update),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  // Watchdog so the run always ends even if the DUT wedges a wait.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Round to nearest 24-bit value with positive saturation.
  function automatic logic [23:0] ref_round(input logic [IN_W-1:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + (longint'(1) << (IN_W - 25))) >>> (IN_W - 24);
    if (v > 64'sd8388607) v = 64'sd8388607;
    return v[23:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, " level"}, 48'(fifo_level), 48'(model_q.size()));
    checkOutput({tag, " overflow"}, 48'(overflow), 48'(exp_ovf));
    checkOutput({tag, " underflow"}, 48'(underflow), 48'(exp_unf));
  endtask

  // One push cycle with no frame edge anywhere near it.
  task automatic applyStimulus(input logic [IN_W-1:0] r, input logic [IN_W-1:0] i);
    @(negedge clock);
    in_real  = r;
    in_imag  = i;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back({ref_round(r), ref_round(i)});
    else exp_ovf = 1'b1;
  endtask

  // One LRCLK pulse; expects a release if the model holds data, else a hold.
  task automatic frameEdge(input string tag);
    logic seen;
    logic expect_upd;
    @(negedge clock);
    LRCLK = 1'b1;
    expect_upd = (model_q.size() != 0);
    seen = 1'b0;
    for (int c = 0; c < SYNC_STAGES + 5 && !seen; c++) begin
      @(negedge clock);
      if (out_update) seen = 1'b1;
    end
    if (expect_upd) begin
      exp_out = model_q.pop_front();
      checkOutput({tag, " update"}, 48'(seen), 48'd1);
      checkOutput({tag, " data"}, {out_real, out_imag}, exp_out);
    end else begin
      exp_unf = 1'b1;
      checkOutput({tag, " no update"}, 48'(seen), 48'd0);
      checkOutput({tag, " hold"}, {out_real, out_imag}, exp_out);
    end
    LRCLK = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock);
  endtask

  // LRCLK pulse with a push placed exactly on the detected-edge cycle.
  task automatic pushOnEdge(input string tag, input logic [IN_W-1:0] r, input logic [IN_W-1:0] i);
    logic had;
    @(negedge clock);
    LRCLK = 1'b1;
    repeat (SYNC_STAGES) @(posedge clock);
    @(negedge clock);
    in_real  = r;
    in_imag  = i;
    in_valid = 1'b1;
    had = (model_q.size() != 0);
    @(negedge clock);
    in_valid = 1'b0;
    if (had) exp_out = model_q.pop_front();
    else exp_unf = 1'b1;
    model_q.push_back({ref_round(r), ref_round(i)});
    checkOutput({tag, " update"}, 48'(out_update), 48'(had));
    checkOutput({tag, " data"}, {out_real, out_imag}, exp_out);
    checkFlags(tag);
    LRCLK = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock);
  endtask

  task automatic clearFlags();
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0] round_in [4];
    logic [IN_W-1:0] round_im [4];
    logic [23:0]     round_exp [4];
    logic            seen;
    int              late;

    round_in  = '{32'h7FFFFFFF, 32'h000000FF, 32'h0000007F, 32'h80000000};
    round_im  = '{32'h00000080, 32'hFFFFFF80, 32'hFFFFFF7F, 32'h12345678};
    round_exp = '{24'h7FFFFF, 24'h000001, 24'h000000, 24'h800000};

    reset       = 1'b1;
    LRCLK       = 1'b0;
    in_valid    = 1'b0;
    clear_flags = 1'b0;
    in_real     = '0;
    in_imag     = '0;
    exp_out     = '0;
    exp_ovf     = 1'b0;
    exp_unf     = 1'b0;

    repeat (3) @(negedge clock);
    checkOutput("reset out", {out_real, out_imag}, 48'd0);
    checkOutput("reset update", 48'(out_update), 48'd0);
    checkFlags("reset");
    reset = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock);

    // Rounding and saturation corners
    for (int k = 0; k < 4; k++) applyStimulus(round_in[k], round_im[k]);
    checkFlags("round fill");
    for (int k = 0; k < 4; k++) begin
      frameEdge("round");
      checkOutput("round const", 48'(out_real), 48'(round_exp[k]));
    end
    checkFlags("round drain");

    // Ordering with pointer wrap, level kept small
    for (int k = 0; k < 20; k++) begin
      applyStimulus(IN_W'(k << 8), IN_W'(-(k << 8)));
      if (k >= 2) frameEdge("order");
    end
    frameEdge("order tail");
    frameEdge("order tail");
    checkFlags("order");

    // Overflow: ten pushes into an eight-deep FIFO
    for (int k = 0; k < DEPTH + 2; k++) applyStimulus(IN_W'((k + 1) << 8), $urandom);
    checkOutput("ovf level const", 48'(fifo_level), 48'(DEPTH));
    checkOutput("ovf flag const", 48'(overflow), 48'd1);
    for (int k = 0; k < DEPTH; k++) frameEdge("ovf drain");
    checkOutput("ovf last const", 48'(out_real), 48'(DEPTH));
    checkFlags("ovf");
    clearFlags();

    // Underflow with a push on the same edge cycle
    pushOnEdge("unf push", 32'h00000100, 32'h00000200);
    checkOutput("unf flag const", 48'(underflow), 48'd1);
    frameEdge("unf next");
    checkOutput("unf next const", 48'(out_real), 48'h000001);

    // Full FIFO with simultaneous push and pop
    clearFlags();
    for (int k = 0; k < DEPTH; k++) applyStimulus($urandom, $urandom);
    pushOnEdge("full pushpop", $urandom, $urandom);
    checkOutput("full level const", 48'(fifo_level), 48'(DEPTH));
    checkOutput("full ovf const", 48'(overflow), 48'd0);
    clearFlags();
    checkFlags("cleared");
    @(negedge clock);
    in_real     = $urandom;
    in_imag     = $urandom;
    in_valid    = 1'b1;
    clear_flags = 1'b1;
    @(negedge clock);
    in_valid    = 1'b0;
    clear_flags = 1'b0;
    exp_ovf     = 1'b1;
    checkOutput("clear race ovf", 48'(overflow), 48'd1);
    checkFlags("clear race");

    // Randomised mix of pushes and frames
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) applyStimulus($urandom, $urandom);
      else frameEdge("rand");
    end
    checkFlags("rand");
    clearFlags();

    // Async reset mid-stream with LRCLK held high
    while (model_q.size() > 6) frameEdge("pre reset");
    while (model_q.size() < 6) applyStimulus($urandom, $urandom);
    @(negedge clock);
    LRCLK = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < SYNC_STAGES + 5 && !seen; c++) begin
      @(negedge clock);
      if (out_update) seen = 1'b1;
    end
    exp_out = model_q.pop_front();
    checkOutput("pre reset update", 48'(seen), 48'd1);
    checkOutput("pre reset data", {out_real, out_imag}, exp_out);
    checkOutput("pre reset level", 48'(fifo_level), 48'd5);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    exp_out = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    checkOutput("async out", {out_real, out_imag}, 48'd0);
    checkOutput("async update", 48'(out_update), 48'd0);
    checkFlags("async");
    @(negedge clock);
    reset = 1'b0;
    late = 0;
    repeat (SYNC_STAGES + 8) begin
      @(negedge clock);
      if (out_update || underflow) late++;
    end
    checkOutput("no edge after reset", 48'(late), 48'd0);
    LRCLK = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clock);
    applyStimulus(32'h00000300, 32'hFFFFFD00);
    frameEdge("post reset");
    checkFlags("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
